// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above start, with wrap.
module rr_picker import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [owner_w(NUM_REQ)-1:0] start,
  output logic [owner_w(NUM_REQ)-1:0] winner,
  output logic                        valid
);

  localparam int IW = owner_w(NUM_REQ);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester overrides.
  always_comb begin
    winner = start;
    valid  = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IW'(idx)]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_BURST_EN for packet/burst grants; otherwise every grant is one beat.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy,
  output logic [owner_w(NUM_REQ)-1:0]   owner
);

  localparam int            OW       = owner_w(NUM_REQ);
  localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQ - 1);

  arb_state_t    state, state_nxt;
  logic [OW-1:0] owner_nxt, rr_ptr, rr_nxt, pick;
  logic          pick_vld, beat, rel_own;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .start  (rr_ptr),
    .winner (pick),
    .valid  (pick_vld)
  );

  // Beat accept is combinational so the FIFO sees winc before the edge it writes on.
  assign beat  = (state == ARB_OWN) && req[owner] && !wfull;
  assign gnt   = beat ? (NUM_REQ'(1) << owner) : '0;
  assign winc  = beat;
  assign wdata = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
  assign busy  = (state == ARB_OWN);

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] beat_cnt, cnt_nxt;

  // Last-beat and burst-cap on the same beat collapse into one release.
  assign rel_own = (state == ARB_OWN) &&
                   (!req[owner] ||
                    (beat && (req_last[owner] || beat_cnt == CW'(MAX_BURST - 1))));

  always_comb begin
    cnt_nxt = beat_cnt;
    if (state == ARB_IDLE) cnt_nxt = '0;
    else if (beat)         cnt_nxt = beat_cnt + 1'b1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) beat_cnt <= '0;
    else         beat_cnt <= cnt_nxt;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^req_last ^ (MAX_BURST > 0);
  assign rel_own    = (state == ARB_OWN) && (!req[owner] || beat);
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_nxt = ARB_OWN;
          owner_nxt = pick;
        end
      end
      ARB_OWN: begin
        if (rel_own) begin
          state_nxt = ARB_IDLE;
          rr_nxt    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter; expectations follow FIFO_WR_ARB_BURST_EN when defined.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } wr_t;

  logic             wclk = 1'b0;
  logic             wrst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    gnt;
  logic             wfull;
  logic             winc;
  logic [DW-1:0]    wdata;
  logic             busy;
  logic [1:0]       owner;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .gnt      (gnt),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .owner    (owner)
  );

  // Producer model: each requester presents the word at its head until granted.
  logic [7:0]    pd [NR][16];
  logic          pl [NR][16];
  int            hd [NR];
  int            tl [NR];
  logic [NR-1:0] en;
  wr_t           sb [$];

  int   checks = 0;
  int   errors = 0;
  int   nwr, ng, idle_run;
  int   gown [64];
  int   gbeats [64];
  int   gap [64];
  logic prev_busy;
  logic s_winc, s_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] w(input int i, input int j);
    return 8'(8'h80 + i * 16 + j);
  endfunction

  task automatic add_word(input int i, input int j, input logic last);
    pd[i][tl[i]] = w(i, j);
    pl[i][tl[i]] = last;
    tl[i]++;
  endtask

  task automatic push_exp(input int i, input int j);
    wr_t e;
    e.idx  = 2'(i);
    e.data = w(i, j);
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && hd[i] < tl[i]) begin
        req[i]             = 1'b1;
        req_data[i*DW +: DW] = pd[i][hd[i]];
        req_last[i]        = pl[i][hd[i]];
      end else begin
        req[i]             = 1'b0;
        req_data[i*DW +: DW] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    wfull = 1'b0;
    en    = '0;
    sb.delete();
    for (int i = 0; i < NR; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    nwr       = 0;
    ng        = 0;
    idle_run  = 0;
    prev_busy = 1'b0;
    drive();
  endtask

  task automatic cycle();
    logic [NR-1:0] g;
    wr_t           e;
    @(negedge wclk);
    g      = gnt;
    s_winc = winc;
    s_busy = busy;
    if (winc) begin
      nwr++;
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(wdata), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("write_gnt", 32'(gnt), 32'(1) << e.idx);
        check("write_data", 32'(wdata), 32'(e.data));
      end
    end else begin
      check("gnt_without_winc", 32'(gnt), '0);
    end
    if (busy && !prev_busy && ng < 64) begin
      gown[ng]   = int'(owner);
      gbeats[ng] = 0;
      gap[ng]    = idle_run;
      ng++;
      idle_run   = 0;
    end else if (!busy) begin
      idle_run++;
    end
    if (busy && winc && ng > 0) gbeats[ng-1]++;
    prev_busy = busy;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NR; i++) if (g[i]) hd[i]++;
    drive();
  endtask

  task automatic run_until(input int n, input int bound, input string tag);
    for (int k = 0; k < bound && nwr < n; k++) cycle();
    check(tag, nwr, n);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    clear_all();
    @(posedge wclk);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    logic pend;
    req = '0; req_data = '0; req_last = '0;
    wrst_n = 1'b0;
    clear_all();

    // Reset with every requester asking, then fair rotation with 2-beat packets.
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 4; j++) add_word(i, j, (j % 2) == 1);
    en = 4'hF;
    drive();
    for (int k = 0; k < 2; k++) begin
      @(negedge wclk);
      check("rst_gnt", 32'(gnt), '0);
      check("rst_winc", 32'(winc), '0);
      check("rst_busy", 32'(busy), '0);
      check("rst_owner", 32'(owner), '0);
      check("rst_wdata", 32'(wdata), 32'(w(0, 0)));
    end
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    if (BURST) begin
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < NR; i++) begin
          push_exp(i, 2*r);
          push_exp(i, 2*r + 1);
        end
    end else begin
      for (int j = 0; j < 4; j++)
        for (int i = 0; i < NR; i++) push_exp(i, j);
    end
    run_until(16, 120, "rot_writes");
    repeat (3) cycle();
    check("rot_sb_empty", sb.size(), 0);
    for (int k = 0; k < 5; k++) begin
      check("rot_owner", gown[k], k % NR);
      check("rot_beats", gbeats[k], BURST ? 2 : 1);
      if (k > 0) check("rot_gap", gap[k], 1);
    end

    // Lone requester hits the burst cap and is re-granted after one idle cycle.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      add_word(2, j, 1'b0);
      push_exp(2, j);
    end
    en = 4'b0100;
    drive();
    run_until(8, 60, "cap_writes");
    repeat (3) cycle();
    check("cap_grants", ng, BURST ? 2 : 8);
    check("cap_beats0", gbeats[0], BURST ? MB : 1);
    check("cap_beats1", gbeats[1], BURST ? MB : 1);
    check("cap_owner1", gown[1], 2);
    check("cap_gap", gap[1], 1);

    // Backpressure: wfull for 3 cycles after the first beat of a 4-beat packet.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      add_word(0, j, j == 3);
      push_exp(0, j);
    end
    en = 4'b0001;
    drive();
    run_until(1, 10, "bp_first");
    wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_winc", s_winc, 1'b0);
      check("bp_busy", s_busy, (BURST || k > 0) ? 1'b1 : 1'b0);
`ifdef FIFO_WR_ARB_BURST_EN
      check("bp_beat_cnt", 32'(dut.beat_cnt), 1);
`endif
    end
    wfull = 1'b0;
    run_until(4, 20, "bp_writes");
    repeat (3) cycle();
    check("bp_sb_empty", sb.size(), 0);
    check("bp_grants", ng, BURST ? 1 : 4);
    check("bp_beats0", gbeats[0], BURST ? 4 : 1);

    // Owner 1 drops its request after one beat; search resumes at 2.
    do_reset();
    add_word(1, 0, 1'b0);
    add_word(1, 1, 1'b0);
    add_word(3, 0, 1'b1);
    add_word(0, 0, 1'b1);
    push_exp(1, 0);
    push_exp(3, 0);
    push_exp(0, 0);
    en = 4'b1010;
    drive();
    run_until(1, 10, "drop_first");
    en = 4'b1001;
    drive();
    run_until(3, 20, "drop_writes");
    repeat (3) cycle();
    check("drop_grants", ng, 3);
    check("drop_owner0", gown[0], 1);
    check("drop_owner1", gown[1], 3);
    check("drop_owner2", gown[2], 0);
    check("drop_beats0", gbeats[0], 1);

    // Reset during beat 2: only the completed beat reaches the FIFO.
    do_reset();
    for (int j = 0; j < 4; j++) add_word(0, j, j == 3);
    push_exp(0, 0);
    en = 4'b0001;
    drive();
    run_until(1, 10, "mb_first");
    pend = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      if (winc) begin
        pend = 1'b1;
        break;
      end
    end
    check("mb_beat2_pending", pend, 1'b1);
    #2;
    wrst_n = 1'b0;
    #1;
    check("mb_rst_winc", 32'(winc), '0);
    check("mb_rst_gnt", 32'(gnt), '0);
    check("mb_rst_busy", 32'(busy), '0);
    check("mb_writes", nwr, 1);
    check("mb_sb_empty", sb.size(), 0);
    @(posedge wclk);
    #1;
    clear_all();
    add_word(0, 5, 1'b1);
    add_word(1, 5, 1'b1);
    push_exp(0, 5);
    push_exp(1, 5);
    en = 4'b0011;
    wrst_n = 1'b1;
    drive();
    run_until(2, 20, "mb_after_writes");
    repeat (2) cycle();
    check("mb_after_owner0", gown[0], 0);
    check("mb_after_owner1", gown[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
